// File: rtl/cmd_frame_assembler.sv
// Command-frame assembler: gathers FRAME_BYTES toggle-announced bytes (MSB first) into a frame,
// hands it over with valid/ready, decodes the opcode and reports overrun/timeout in a status byte.
module cmd_frame_assembler #(
    parameter int unsigned FRAME_BYTES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_byte,
    input  logic                     byte_finished,
    input  logic                     frame_ready,
    output logic                     frame_valid,
    output logic [8*FRAME_BYTES-1:0] frame_data,
    output logic [5:0]               opcode,
    output logic                     unknown_cmd,
    output logic                     overrun,
    output logic                     timeout_err,
    output logic [7:0]               out_byte
);

    localparam int unsigned DATA_W = 8 * FRAME_BYTES;
    localparam int unsigned CNT_W  = $clog2(FRAME_BYTES + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(FRAME_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDLE_W-1:0]   r_idle;
    logic [DATA_W-1:0]   r_frame_data;
    logic                r_valid;
    logic                r_unknown;
    logic                r_overrun;
    logic                r_timeout;
    logic                r_ovr_sticky;
    logic                r_to_sticky;
    logic [7:0]          r_out_byte;

    state_t              w_state_nxt;
    logic                w_strobe;
    logic                w_store;
    logic [CNT_W-1:0]    w_slot;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDLE_W-1:0]   w_idle_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_valid_nxt;
    logic                w_unknown_nxt;
    logic                w_overrun_nxt;
    logic                w_timeout_nxt;
    logic                w_ovr_sticky_nxt;
    logic                w_to_sticky_nxt;
    logic                w_op_unknown;

    // Either edge of the synchronised toggle announces a new byte.
    assign w_strobe = r_sync2 ^ r_prev;

    // Byte 0 is already stored whenever the last slot is written, so decode reads the register.
    assign w_op_unknown = (r_frame_data[DATA_W-3 -: 6] > 6'd2);

    always_comb begin
        w_state_nxt      = r_state;
        w_store          = 1'b0;
        w_slot           = r_cnt;
        w_cnt_nxt        = r_cnt;
        w_idle_nxt       = r_idle;
        w_valid_nxt      = r_valid;
        w_unknown_nxt    = r_unknown;
        w_overrun_nxt    = 1'b0;
        w_timeout_nxt    = 1'b0;
        w_ovr_sticky_nxt = r_ovr_sticky;
        w_to_sticky_nxt  = r_to_sticky;

        case (r_state)
            S_IDLE: begin
                w_idle_nxt = '0;
                if (w_strobe) begin
                    w_store          = 1'b1;
                    w_slot           = '0;
                    w_cnt_nxt        = CNT_W'(1);
                    w_ovr_sticky_nxt = 1'b0;
                    w_to_sticky_nxt  = 1'b0;
                    w_state_nxt      = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_strobe) begin
                    w_store    = 1'b1;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    w_idle_nxt = '0;
                    if (r_cnt == LAST_SLOT) begin
                        w_valid_nxt   = 1'b1;
                        w_unknown_nxt = w_op_unknown;
                        w_state_nxt   = S_HOLD;
                    end
                end else if (r_idle == IDLE_MAX) begin
                    w_timeout_nxt   = 1'b1;
                    w_to_sticky_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_idle_nxt      = '0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_idle_nxt = r_idle + IDLE_W'(1);
                end
            end
            S_HOLD: begin
                if (frame_ready) begin
                    w_valid_nxt   = 1'b0;
                    w_unknown_nxt = 1'b0;
                    // A byte landing on the handshake cycle opens the next frame instead of being lost.
                    if (w_strobe) begin
                        w_store          = 1'b1;
                        w_slot           = '0;
                        w_cnt_nxt        = CNT_W'(1);
                        w_ovr_sticky_nxt = 1'b0;
                        w_to_sticky_nxt  = 1'b0;
                        w_state_nxt      = S_COLLECT;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_strobe) begin
                    w_overrun_nxt    = 1'b1;
                    w_ovr_sticky_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Slot writer: slot k lands in byte lane FRAME_BYTES-1-k.
    always_comb begin
        w_data_nxt = r_frame_data;
        if (w_store) begin
            for (int i = 0; i < int'(FRAME_BYTES); i++) begin
                if (w_slot == CNT_W'(i)) begin
                    w_data_nxt[8*(int'(FRAME_BYTES)-1-i) +: 8] = in_byte;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_prev       <= 1'b0;
            r_cnt        <= '0;
            r_idle       <= '0;
            r_frame_data <= '0;
            r_valid      <= 1'b0;
            r_unknown    <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
            r_ovr_sticky <= 1'b0;
            r_to_sticky  <= 1'b0;
            r_out_byte   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sync1      <= byte_finished;
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            r_cnt        <= w_cnt_nxt;
            r_idle       <= w_idle_nxt;
            r_frame_data <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_unknown    <= w_unknown_nxt;
            r_overrun    <= w_overrun_nxt;
            r_timeout    <= w_timeout_nxt;
            r_ovr_sticky <= w_ovr_sticky_nxt;
            r_to_sticky  <= w_to_sticky_nxt;
            r_out_byte   <= {w_valid_nxt, w_ovr_sticky_nxt, w_to_sticky_nxt,
                             w_unknown_nxt, 4'(w_cnt_nxt)};
        end
    end

    assign frame_valid = r_valid;
    assign frame_data  = r_frame_data;
    assign opcode      = r_frame_data[DATA_W-3 -: 6];
    assign unknown_cmd = r_unknown;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout;
    assign out_byte    = r_out_byte;

endmodule

// File: tb/tb_cmd_frame_assembler.sv
// Directed bench for cmd_frame_assembler: vector table of whole frames plus hand-written
// overrun, timeout, handshake-collision and reset sequences on 2/4/8-byte instances.
module tb_cmd_frame_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_finished;
    logic        ready4;
    logic        ready_off;
    logic [7:0]  in_byte;

    logic        valid4, unk4, ovr4, to4;
    logic [31:0] data4;
    logic [5:0]  op4;
    logic [7:0]  ob4;

    logic        valid2, unk2, ovr2, to2;
    logic [15:0] data2;
    logic [5:0]  op2;
    logic [7:0]  ob2;

    logic        valid8, unk8, ovr8, to8;
    logic [63:0] data8;
    logic [5:0]  op8;
    logic [7:0]  ob8;

    int n_vec   = 0;
    int n_err   = 0;
    int ovr_cnt = 0;
    int to_cnt  = 0;

    always #5 clk = ~clk;

    cmd_frame_assembler #(.FRAME_BYTES(4), .TIMEOUT_CYCLES(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .byte_finished(byte_finished),
        .frame_ready(ready4), .frame_valid(valid4), .frame_data(data4), .opcode(op4),
        .unknown_cmd(unk4), .overrun(ovr4), .timeout_err(to4), .out_byte(ob4));

    cmd_frame_assembler #(.FRAME_BYTES(2), .TIMEOUT_CYCLES(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .byte_finished(byte_finished),
        .frame_ready(ready_off), .frame_valid(valid2), .frame_data(data2), .opcode(op2),
        .unknown_cmd(unk2), .overrun(ovr2), .timeout_err(to2), .out_byte(ob2));

    cmd_frame_assembler #(.FRAME_BYTES(8), .TIMEOUT_CYCLES(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .byte_finished(byte_finished),
        .frame_ready(ready_off), .frame_valid(valid8), .frame_data(data8), .opcode(op8),
        .unknown_cmd(unk8), .overrun(ovr8), .timeout_err(to8), .out_byte(ob8));

    // Count pulse cycles of the 4-byte instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (ovr4) ovr_cnt++;
        if (to4)  to_cnt++;
    end

    typedef struct {
        logic [31:0] frame;
        logic [5:0]  op;
        logic        unk;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_byte       = b;
        byte_finished = ~byte_finished;
        tick(6);
    endtask

    task automatic send4(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic handshake();
        ready4 = 1'b1;
        tick(1);
        ready4 = 1'b0;
    endtask

    initial begin
        int base;

        vecs[0] = '{frame: 32'h01AA550F, op: 6'h01, unk: 1'b0};
        vecs[1] = '{frame: 32'h3F123456, op: 6'h3F, unk: 1'b1};
        vecs[2] = '{frame: 32'hC2ABCDEF, op: 6'h02, unk: 1'b0};
        vecs[3] = '{frame: 32'h80FFFFFF, op: 6'h00, unk: 1'b0};
        vecs[4] = '{frame: 32'h43010203, op: 6'h03, unk: 1'b1};

        rst_n         = 1'b0;
        byte_finished = 1'b0;
        in_byte       = 8'h00;
        ready4        = 1'b0;
        ready_off     = 1'b0;
        tick(3);
        chk("reset_valid", 64'(valid4), 64'h0);
        chk("reset_data", 64'(data4), 64'h0);
        chk("reset_status", 64'(ob4), 64'h0);
        rst_n = 1'b1;
        tick(2);

        // Whole frames: data, decode, status byte, then release.
        for (int i = 0; i < 5; i++) begin
            send4(vecs[i].frame);
            chk("tbl_valid", 64'(valid4), 64'h1);
            chk("tbl_data", 64'(data4), 64'(vecs[i].frame));
            chk("tbl_opcode", 64'(op4), 64'(vecs[i].op));
            chk("tbl_unknown", 64'(unk4), 64'(vecs[i].unk));
            chk("tbl_status", 64'(ob4), 64'({4'b1000, 4'd4} | (8'(vecs[i].unk) << 4)));
            handshake();
            chk("tbl_valid_drop", 64'(valid4), 64'h0);
            chk("tbl_unknown_drop", 64'(unk4), 64'h0);
            chk("tbl_status_idle", 64'(ob4), 64'h00);
        end

        // Extra byte while the frame is held.
        send4(32'h01AA550F);
        base = ovr_cnt;
        send_byte(8'h77);
        chk("ovr_pulse", 64'(ovr_cnt - base), 64'd1);
        chk("ovr_data_kept", 64'(data4), 64'h01AA550F);
        chk("ovr_valid_kept", 64'(valid4), 64'h1);
        chk("ovr_status", 64'(ob4), 64'hC4);
        handshake();
        chk("ovr_release", 64'(valid4), 64'h0);
        chk("ovr_sticky_idle", 64'(ob4), 64'h40);

        // Stalled partial frame.
        base = to_cnt;
        send_byte(8'h12);
        send_byte(8'h34);
        tick(12);
        chk("to_not_early", 64'(to_cnt - base), 64'd0);
        tick(2);
        chk("to_pulse", 64'(to_cnt - base), 64'd1);
        chk("to_status", 64'(ob4), 64'h20);
        tick(20);
        chk("to_no_repeat", 64'(to_cnt - base), 64'd1);
        send4(32'h00112233);
        chk("to_next_data", 64'(data4), 64'h00112233);
        chk("to_sticky_clear", 64'(ob4), 64'h84);
        handshake();

        // Byte strobe lands on the handshake edge.
        send4(32'h01020304);
        base          = ovr_cnt;
        in_byte       = 8'h02;
        byte_finished = ~byte_finished;
        tick(2);
        ready4 = 1'b1;
        tick(1);
        ready4 = 1'b0;
        chk("hs_valid_drop", 64'(valid4), 64'h0);
        tick(2);
        chk("hs_no_overrun", 64'(ovr_cnt - base), 64'd0);
        chk("hs_status_cnt1", 64'(ob4), 64'h01);
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        chk("hs_next_data", 64'(data4), 64'h020A0B0C);
        chk("hs_next_opcode", 64'(op4), 64'h02);
        chk("hs_next_unknown", 64'(unk4), 64'h0);
        handshake();

        // Reset in the middle of a frame, then rebuild on all widths.
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        rst_n         = 1'b0;
        byte_finished = 1'b0;
        #1;
        chk("rst_data", 64'(data4), 64'h0);
        chk("rst_valid", 64'(valid4), 64'h0);
        chk("rst_opcode", 64'(op4), 64'h0);
        chk("rst_flags", 64'({unk4, ovr4, to4}), 64'h0);
        chk("rst_status", 64'(ob4), 64'h0);
        chk("rst_w2", 64'({valid2, data2, ob2}), 64'h0);
        chk("rst_w8", 64'({valid8, ob8}), 64'h0);
        chk("rst_w8_data", data8, 64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send4(32'hDEADBEEF);
        chk("post_rst_w4", 64'(data4), 64'hDEADBEEF);
        chk("post_rst_w4_valid", 64'(valid4), 64'h1);
        chk("w2_data", 64'(data2), 64'hDEAD);
        chk("w2_valid", 64'(valid2), 64'h1);
        chk("w2_status", 64'(ob2), 64'hD2);
        send4(32'h01234567);
        chk("w8_data", data8, 64'hDEADBEEF01234567);
        chk("w8_valid", 64'(valid8), 64'h1);
        chk("w8_opcode", 64'(op8), 64'h1E);
        chk("w8_status", 64'(ob8), 64'h98);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
